// File: rtl/rgb_layer_mux.sv
// rgb_layer_mux
//   Two-stage pixel-colour selector sitting between the layer generators and
//   the VGA DAC registers. Each pixel picks one of NUM_LAYERS RGB sources
//   from a visibility mask. The mask is first gated by per-layer blinking,
//   which is timed in frames. Blanking pixels are forced to black.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   pixel_en     pixel strobe; the pipeline advances only when high
//   frame_start  one-cycle pulse at the start of each frame
//   active_video pixel lies in the visible area
//   mode         0 = strict one-hot, 1 = priority (lowest index wins)
//   visible      per-layer visibility
//   blink_mask   per-layer blink participation
//   rgb_in       packed layer colours, layer i at [i*COLOR_W +: COLOR_W]
//   rgb_out      selected colour (registered)
//   rgb_valid    rgb_out holds a pixel that has completed the pipeline
//   conflict     more than one effective layer was visible (aligned with rgb_out)
//   blink_phase  current blink phase (registered)
module rgb_layer_mux #(
    parameter int unsigned          NUM_LAYERS = 4,
    parameter int unsigned          COLOR_W    = 24,
    parameter logic [COLOR_W-1:0]   BG_COLOR   = 24'hFFFFFF,
    parameter int unsigned          BLINK_DIV  = 30
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pixel_en,
    input  logic                            frame_start,
    input  logic                            active_video,
    input  logic                            mode,
    input  logic [NUM_LAYERS-1:0]           visible,
    input  logic [NUM_LAYERS-1:0]           blink_mask,
    input  logic [NUM_LAYERS*COLOR_W-1:0]   rgb_in,
    output logic [COLOR_W-1:0]              rgb_out,
    output logic                            rgb_valid,
    output logic                            conflict,
    output logic                            blink_phase
);

    localparam int unsigned       CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]       r_blink_cnt;
    logic                   r_blink_phase;

    logic [NUM_LAYERS-1:0]  w_eff;
    logic                   w_any;
    logic                   w_multi;
    logic [COLOR_W-1:0]     w_win;
    logic [COLOR_W-1:0]     w_s1_color;

    logic [COLOR_W-1:0]     r_s1_color;
    logic                   r_s1_conflict;
    logic                   r_s1_active;
    logic                   r_s1_valid;

    logic [COLOR_W-1:0]     r_rgb_out;
    logic                   r_conflict;
    logic                   r_valid;

    // Frame-based blink timer; runs regardless of pixel_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (r_blink_cnt == CNT_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + CNT_W'(1);
            end
        end
    end

    // The scan records the lowest-index winner and detects a second set
    // bit in the same pass, so priority select and conflict share one loop.
    // For exactly one set bit, the lowest-index winner is also the one-hot pick.
    always_comb begin
        w_eff   = visible & ~(blink_mask & {NUM_LAYERS{r_blink_phase}});
        w_any   = 1'b0;
        w_multi = 1'b0;
        w_win   = BG_COLOR;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (w_eff[i]) begin
                if (!w_any) begin
                    w_win = rgb_in[i*COLOR_W +: COLOR_W];
                end
                w_multi = w_multi | w_any;
                w_any   = 1'b1;
            end
        end
        w_s1_color = (!mode && w_multi) ? BG_COLOR : w_win;
    end

    // Stage 1: selection result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_color    <= '0;
            r_s1_conflict <= 1'b0;
            r_s1_active   <= 1'b0;
            r_s1_valid    <= 1'b0;
        end else if (pixel_en) begin
            r_s1_color    <= w_s1_color;
            r_s1_conflict <= w_multi;
            r_s1_active   <= active_video;
            r_s1_valid    <= 1'b1;
        end
    end

    // Stage 2: blanking and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb_out  <= '0;
            r_conflict <= 1'b0;
            r_valid    <= 1'b0;
        end else if (pixel_en) begin
            r_valid <= r_s1_valid;
            if (r_s1_active) begin
                r_rgb_out  <= r_s1_color;
                r_conflict <= r_s1_conflict;
            end else begin
                r_rgb_out  <= '0;
                r_conflict <= 1'b0;
            end
        end
    end

    assign rgb_out     = r_rgb_out;
    assign rgb_valid   = r_valid;
    assign conflict    = r_conflict;
    assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_rgb_layer_mux.sv
module tb_rgb_layer_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 24;
    localparam int unsigned BD = 2;
    localparam logic [CW-1:0] BG = 24'hFFFFFF;

    logic            clk = 1'b0;
    logic            rst;
    logic            pixel_en;
    logic            frame_start;
    logic            active_video;
    logic            mode;
    logic [N-1:0]    visible;
    logic [N-1:0]    blink_mask;
    logic [N*CW-1:0] rgb_in;
    logic [CW-1:0]   rgb_out;
    logic            rgb_valid;
    logic            conflict;
    logic            blink_phase;

    rgb_layer_mux #(
        .NUM_LAYERS (N),
        .COLOR_W    (CW),
        .BG_COLOR   (BG),
        .BLINK_DIV  (BD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_en     (pixel_en),
        .frame_start  (frame_start),
        .active_video (active_video),
        .mode         (mode),
        .visible      (visible),
        .blink_mask   (blink_mask),
        .rgb_in       (rgb_in),
        .rgb_out      (rgb_out),
        .rgb_valid    (rgb_valid),
        .conflict     (conflict),
        .blink_phase  (blink_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] rgb;
        logic          conf;
    } pix_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   frames   = 0;
    logic m_phase  = 1'b0;
    pix_t q[$];
    pix_t cur;
    logic cur_valid = 1'b0;

    logic [N*CW-1:0] plan_rgb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference: count effective layers, then apply the selection rules.
    function automatic pix_t model_pix(input logic av, input logic md,
                                       input logic [N-1:0] vis, input logic [N-1:0] bm,
                                       input logic [N*CW-1:0] rgb, input logic ph);
        pix_t r;
        logic [N-1:0] eff;
        int cnt;
        int first;
        eff   = ph ? (vis & ~bm) : vis;
        cnt   = $countones(eff);
        first = -1;
        for (int i = N - 1; i >= 0; i--) if (eff[i]) first = i;
        if (!av) begin
            r.rgb = '0; r.conf = 1'b0;
        end else if (cnt == 0) begin
            r.rgb = BG; r.conf = 1'b0;
        end else if (!md && cnt > 1) begin
            r.rgb = BG; r.conf = 1'b1;
        end else begin
            r.rgb  = rgb[first*CW +: CW];
            r.conf = (cnt > 1);
        end
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        cur_valid = 1'b0;
        cur.rgb   = '0;
        cur.conf  = 1'b0;
        frames    = 0;
        m_phase   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 64'(rgb_valid), 64'(cur_valid));
        chk({tag, "_rgb"},   64'(rgb_out),   cur_valid ? 64'(cur.rgb)  : 64'(0));
        chk({tag, "_conf"},  64'(conflict),  cur_valid ? 64'(cur.conf) : 64'(0));
        chk({tag, "_phase"}, 64'(blink_phase), 64'(m_phase));
    endtask

    // Drive one clock of stimulus; inputs change 1 time unit after the edge.
    task automatic step(input string tag, input logic pe, input logic fs, input logic av,
                        input logic md, input logic [N-1:0] vis, input logic [N-1:0] bm,
                        input logic [N*CW-1:0] rgb);
        pix_t res;
        pixel_en = pe; frame_start = fs; active_video = av; mode = md;
        visible = vis; blink_mask = bm; rgb_in = rgb;
        res = model_pix(av, md, vis, bm, rgb, m_phase);
        @(posedge clk);
        #1;
        if (!rst) begin
            if (pe) begin
                q.push_back(res);
                if (q.size() > 1) begin
                    cur       = q.pop_front();
                    cur_valid = 1'b1;
                end
            end
            if (fs) frames++;
            m_phase = ((frames / BD) % 2) == 1;
        end
        check_outputs(tag);
    endtask

    task automatic rand_step(input string tag);
        step(tag, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 8), 1'(($urandom)), N'($urandom), N'($urandom),
             {$urandom, $urandom, $urandom});
    endtask

    initial begin
        rst = 1'b1; pixel_en = 1'b0; frame_start = 1'b0; active_video = 1'b0;
        mode = 1'b0; visible = '0; blink_mask = '0; rgb_in = '0;
        plan_rgb = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h123456};
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Strict one-hot, each result two strobes later; last step flushes
        step("s1", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, plan_rgb);
        step("s2", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, plan_rgb);
        chk("strict_l0", 64'(rgb_out), 64'(24'h123456));
        step("s3", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, plan_rgb);
        chk("strict_l2", 64'(rgb_out), 64'(24'h00FF00));
        step("s4", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 4'b0000, plan_rgb);
        chk("strict_none", 64'(rgb_out), 64'(BG));
        // Priority
        step("p1", 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 4'b0000, plan_rgb);
        chk("strict_multi", 64'({conflict, rgb_out}), 64'({1'b1, BG}));
        step("p2", 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b0000, plan_rgb);
        chk("prio_multi", 64'({conflict, rgb_out}), 64'({1'b1, 24'h00FF00}));
        // Blanking
        step("b1", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, plan_rgb);
        chk("prio_l3", 64'({conflict, rgb_out}), 64'({1'b0, 24'h0000FF}));
        step("b2", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, plan_rgb);
        chk("blank", 64'({rgb_valid, conflict, rgb_out}), 64'({1'b1, 1'b0, 24'h000000}));

        // Blink: frame_start coincident with pixel_en uses the old phase
        for (int k = 0; k < 12; k++)
            step("blink", 1'b1, (k % 3 == 1), 1'b1, 1'b0, 4'b0001, 4'b0001, plan_rgb);

        // Stall with changing inputs, then resume
        for (int k = 0; k < 10; k++)
            step("stall", 1'b0, 1'b0, 1'b1, 1'b0, N'($urandom), 4'b0000, {$urandom, $urandom, $urandom});
        for (int k = 0; k < 4; k++)
            step("resume", 1'b1, 1'b0, 1'b1, 1'(k), 4'(1 << k), 4'b0000, plan_rgb);

        for (int k = 0; k < 200; k++) rand_step("rand");

        // Asynchronous reset mid-stream
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("async_rst_rgb",   64'(rgb_out),     64'(0));
        chk("async_rst_valid", 64'(rgb_valid),   64'(0));
        chk("async_rst_phase", 64'(blink_phase), 64'(0));
        for (int k = 0; k < 3; k++) rand_step("in_rst");
        #2;
        rst = 1'b0;
        step("post_rst1", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, plan_rgb);
        chk("post_rst1_novalid", 64'(rgb_valid), 64'(0));
        step("post_rst2", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, plan_rgb);
        chk("post_rst2_valid", 64'({rgb_valid, rgb_out}), 64'({1'b1, 24'h123456}));

        for (int k = 0; k < 300; k++) rand_step("rand2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
